// File: rtl/scorehand.sv
// Baccarat hand scorer: maps up to three card codes to point values and registers
// the mod-10 total, the natural flag and an illegal-code flag with one cycle of latency.
module scorehand (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] card1,
  input  logic [3:0] card2,
  input  logic [3:0] card3,
  output logic [3:0] total,
  output logic       natural,
  output logic       bad_card
);

  // Only codes 1-9 carry points; empty, court and illegal codes all count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd9) begin
      card_value = code;
    end else begin
      card_value = 4'd0;
    end
  endfunction

  function automatic logic is_bad(input logic [3:0] code);
    is_bad = (code[3:1] == 3'b111);
  endfunction

  logic [4:0] sum;
  logic [3:0] score;
  logic       bad;

  always_comb begin
    sum = {1'b0, card_value(card1)} + {1'b0, card_value(card2)} + {1'b0, card_value(card3)};
    // Sum is at most 27, so two conditional subtractions give an exact mod 10.
    if (sum >= 5'd20) begin
      score = 4'(sum - 5'd20);
    end else if (sum >= 5'd10) begin
      score = 4'(sum - 5'd10);
    end else begin
      score = sum[3:0];
    end
    bad = is_bad(card1) | is_bad(card2) | is_bad(card3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total    <= 4'd0;
      natural  <= 1'b0;
      bad_card <= 1'b0;
    end else begin
      total    <= score;
      natural  <= (score >= 4'd8);
      bad_card <= bad;
    end
  end

endmodule

// File: tb/tb_scorehand.sv
// Directed and exhaustive self-checking bench for scorehand.
module tb_scorehand;

  logic       clk;
  logic       reset;
  logic [3:0] card1;
  logic [3:0] card2;
  logic [3:0] card3;
  logic [3:0] total;
  logic       natural;
  logic       bad_card;

  int vectors;
  int miscompares;

  scorehand dut (
    .clk      (clk),
    .reset    (reset),
    .card1    (card1),
    .card2    (card2),
    .card3    (card3),
    .total    (total),
    .natural  (natural),
    .bad_card (bad_card)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge load, sample 1ns later.
  task automatic apply(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3);
    @(negedge clk);
    card1 = c1;
    card2 = c2;
    card3 = c3;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [3:0] t, input logic n, input logic b);
    check({tag, ".total"}, 32'(total), 32'(t));
    check({tag, ".natural"}, 32'(natural), 32'(n));
    check({tag, ".bad_card"}, 32'(bad_card), 32'(b));
  endtask

  function automatic int ref_value(input int code);
    return (code >= 1 && code <= 9) ? code : 0;
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    card1 = 4'd1;
    card2 = 4'd2;
    card3 = 4'd3;
    #1;
    expect3("reset_async", 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect3("reset_held", 4'd0, 1'b0, 1'b0);

    // First edge after release loads the inputs already present.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    expect3("first_edge_123", 4'd6, 1'b0, 1'b0);

    apply(4'd13, 4'd12, 4'd13);
    expect3("kqk", 4'd0, 1'b0, 1'b0);
    apply(4'd15, 4'd15, 4'd15);
    expect3("bad_fff", 4'd0, 1'b0, 1'b1);
    apply(4'd0, 4'd0, 4'd0);
    expect3("empty", 4'd0, 1'b0, 1'b0);
    apply(4'd9, 4'd9, 4'd9);
    expect3("max27", 4'd7, 1'b0, 1'b0);
    apply(4'd4, 4'd5, 4'd0);
    expect3("nat9", 4'd9, 1'b1, 1'b0);
    apply(4'd10, 4'd8, 4'd0);
    expect3("nat8", 4'd8, 1'b1, 1'b0);
    apply(4'd1, 4'd14, 4'd9);
    expect3("bad14_sum10", 4'd0, 1'b0, 1'b1);
    apply(4'd9, 4'd9, 4'd2);
    expect3("sum20", 4'd0, 1'b0, 1'b0);
    apply(4'd9, 4'd9, 4'd1);
    expect3("sum19", 4'd9, 1'b1, 1'b0);

    // Hold constant, then check a mid-cycle input change waits for the edge.
    apply(4'd9, 4'd9, 4'd1);
    expect3("hold", 4'd9, 1'b1, 1'b0);
    card1 = 4'd2;
    card2 = 4'd2;
    card3 = 4'd0;
    #2;
    expect3("latency_before_edge", 4'd9, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    expect3("latency_after_edge", 4'd4, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    apply(4'd9, 4'd9, 4'd0);
    expect3("pre_reset_998", 4'd8, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    expect3("async_clear", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 16; c++) begin
          int s;
          s = (ref_value(a) + ref_value(b) + ref_value(c)) % 10;
          apply(4'(a), 4'(b), 4'(c));
          check($sformatf("sweep_total_%0d_%0d_%0d", a, b, c), 32'(total), 32'(s));
          check($sformatf("sweep_nat_%0d_%0d_%0d", a, b, c), 32'(natural), 32'(s >= 8));
          check($sformatf("sweep_bad_%0d_%0d_%0d", a, b, c), 32'(bad_card),
                32'(a >= 14 || b >= 14 || c >= 14));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scorehand.md
SCOREHAND -- requirements
Module: scorehand

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high clear of all registers.
REQ-004 The block SHALL have port card1, input, 4 bits: first card code.
REQ-005 The block SHALL have port card2, input, 4 bits: second card code.
REQ-006 The block SHALL have port card3, input, 4 bits: third card code; 0 means no third card.
REQ-007 The block SHALL have port total, output, 4 bits: registered Baccarat hand score, 0-9.
REQ-008 The block SHALL have port natural, output, 1 bit: registered flag, high when total is 8 or 9.
REQ-009 The block SHALL have port bad_card, output, 1 bit: registered flag, high when any input card code is 14 or 15.

Function
REQ-010 Card code mapping SHALL be: 0 = no card, value 0; 1 (Ace) = value 1; 2-9 = face value; 10, 11 (J), 12 (Q), 13 (K) = value 0.
REQ-011 Codes 14 and 15 SHALL be treated as value 0 and SHALL set bad_card.
REQ-012 Score SHALL be (value1 + value2 + value3) mod 10.
REQ-013 The intermediate sum SHALL be at least 5 bits wide; maximum sum 27 SHALL yield 7.
REQ-014 The modulo SHALL be exact for all sums 0-27, e.g. 10 -> 0, 19 -> 9, 20 -> 0.
REQ-015 total, natural and bad_card SHALL be sampled from the card inputs on every rising clk edge.
REQ-016 Latency SHALL be exactly 1 cycle: outputs at cycle N+1 reflect inputs present at the cycle-N edge.
REQ-017 There SHALL be no enable or handshake; inputs held constant SHALL give constant outputs.
REQ-018 natural SHALL be derived from the same computed score registered into total, with no extra cycle of delay.
REQ-019 Outputs SHALL never contain X after reset, for any 4-bit input combination.
REQ-020 total SHALL never exceed 9.

Reset
REQ-021 While reset is high, total SHALL be 0, natural SHALL be 0 and bad_card SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL clear outputs immediately (asynchronously), not at the next edge.
REQ-023 After reset deasserts, the first rising clk edge SHALL load the score of the current inputs.

Verification
REQ-024 The bench SHALL cover: card1=1, card2=2, card3=3, one edge -> total=6, natural=0, bad_card=0.
REQ-025 The bench SHALL cover: cards 13, 12, 13 (K, Q, K) -> total=0, natural=0, bad_card=0.
REQ-026 The bench SHALL cover: cards 15, 15, 15 -> total=0, bad_card=1; then cards 0, 0, 0 -> total=0, bad_card=0.
REQ-027 The bench SHALL cover: cards 9, 9, 9 -> total=7; cards 4, 5, 0 -> total=9, natural=1; cards 10, 8, 0 -> total=8, natural=1.
REQ-028 The bench SHALL cover: load cards 9, 9, 0 (total=8), assert reset between edges -> total=0 and natural=0 immediately.
REQ-029 The bench SHALL cover an exhaustive sweep of all 4096 card combinations, comparing total against the mod-10 reference after each edge.
